itch_feed_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter sharing one itch_decoder (64-bit AXI-Stream sink) among
//  N_FEEDS ingress feeds (A/B multicast lines, replay port). Sits between the per-feed MAC/UDP

---
 rtl/itch_feed_arbiter.sv | 165 ++++++++++++++++
 tb/tb_itch_feed_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itch_feed_arbiter.sv
// Packet-atomic round-robin arbiter that shares one 64-bit AXI-Stream decoder sink among N_FEEDS feeds.
// Optional mid-packet stall watchdog with synthetic terminator: define ITCH_ARB_TIMEOUT_EN.
module itch_feed_arbiter #(
   parameter int N_FEEDS     = 4,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_FEEDS*DATA_W-1:0]   s_axis_tdata,
   input  logic [N_FEEDS-1:0]          s_axis_tvalid,
   input  logic [N_FEEDS-1:0]          s_axis_tlast,
   output logic [N_FEEDS-1:0]          s_axis_tready,
   output logic [DATA_W-1:0]           m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready,
   output logic                        grant_valid,
   output logic [$clog2(N_FEEDS)-1:0]  grant_id,
   output logic                        pkt_done,
   output logic                        err_timeout
);

   localparam int ID_W = $clog2(N_FEEDS);

   typedef enum logic [1:0] {
      IDLE,
      PASS
`ifdef ITCH_ARB_TIMEOUT_EN
      , TERM,
      DRAIN
`endif
   } state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   ptr_nxt;
   logic              found;
   logic [DATA_W-1:0] sel_data;
   logic              sel_valid;
   logic              sel_last;
   logic              accept;
   logic              pkt_end;
   logic              drain_end;
   logic              stall_hit;

   assign sel_data  = s_axis_tdata[int'(grant_id)*DATA_W +: DATA_W];
   assign sel_valid = s_axis_tvalid[grant_id];
   assign sel_last  = s_axis_tlast[grant_id];

   assign accept      = (state == PASS) && sel_valid && m_axis_tready;
   assign pkt_end     = accept && sel_last;
   assign grant_valid = (state != IDLE);
   assign ptr_nxt     = (grant_id == ID_W'(N_FEEDS - 1)) ? '0 : grant_id + 1'b1;

   // Search starts at rr_ptr, so the feed served last is examined last.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < N_FEEDS; i++) begin
         idx = (int'(rr_ptr) + i) % N_FEEDS;
         if (!found && s_axis_tvalid[idx]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
   end

`ifdef ITCH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] stall_cnt;

   assign stall_hit = (state == PASS) && !sel_valid && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign drain_end = (state == DRAIN) && sel_valid && sel_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (state != PASS || accept)
         stall_cnt <= '0;
      else if (!sel_valid)
         stall_cnt <= stall_cnt + 1'b1;
   end
`else
   // Without the watchdog a stalled feed keeps the grant until its tlast arrives.
   localparam int unused_timeout_cyc = TIMEOUT_CYC;

   assign stall_hit = 1'b0;
   assign drain_end = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         if (state == IDLE && found)
            grant_id <= pick;
         if (pkt_end || drain_end)
            rr_ptr <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (found) state_nxt = PASS;
         PASS: begin
            if (pkt_end)
               state_nxt = IDLE;
            else if (stall_hit) begin
`ifdef ITCH_ARB_TIMEOUT_EN
               state_nxt = TERM;
`endif
            end
         end
`ifdef ITCH_ARB_TIMEOUT_EN
         TERM:  if (m_axis_tready) state_nxt = DRAIN;
         DRAIN: if (drain_end) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      s_axis_tready = '0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      pkt_done      = 1'b0;
      err_timeout   = 1'b0;
      case (state)
         PASS: begin
            m_axis_tdata            = sel_data;
            m_axis_tvalid           = sel_valid;
            m_axis_tlast            = sel_last;
            s_axis_tready[grant_id] = m_axis_tready;
            pkt_done                = pkt_end;
            err_timeout             = stall_hit;
         end
`ifdef ITCH_ARB_TIMEOUT_EN
         // Zero-data terminator closes the decoder's open message before the feed is flushed.
         TERM: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
         end
         DRAIN: s_axis_tready[grant_id] = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_itch_feed_arbiter.sv
// Self-checking bench for itch_feed_arbiter: table-driven arbitration vectors plus scoreboarded packet sequences.
module tb_itch_feed_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            feed;
   } exp_t;

   typedef struct {
      logic [N-1:0] mask;
      int           exp_grant;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N*DW-1:0]   s_axis_tdata;
   logic [N-1:0]      s_axis_tvalid;
   logic [N-1:0]      s_axis_tlast;
   logic [N-1:0]      s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic              grant_valid;
   logic [1:0]        grant_id;
   logic              pkt_done;
   logic              err_timeout;

   itch_feed_arbiter #(.N_FEEDS(N), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .grant_valid(grant_valid), .grant_id(grant_id),
      .pkt_done(pkt_done), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   beat_t   feed_q[N][$];
   exp_t    exp_q[$];
   int      grant_log[$];
   logic [N-1:0] hold;
   logic    bp_toggle;
   logic    chk_mirror;
   logic    gv_prev;
   int      n_checks;
   int      n_err;
   int      mbeats;
   int      pd_cnt;
   int      to_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_feeds();
      for (int i = 0; i < N; i++) begin
         if (feed_q[i].size() > 0 && !hold[i]) begin
            s_axis_tvalid[i]          = 1'b1;
            s_axis_tdata[i*DW +: DW]  = feed_q[i][0].data;
            s_axis_tlast[i]           = feed_q[i][0].last;
         end else begin
            s_axis_tvalid[i]          = 1'b0;
            s_axis_tdata[i*DW +: DW]  = '0;
            s_axis_tlast[i]           = 1'b0;
         end
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) feed_q[i].delete();
      hold = '0;
      drive_feeds();
   endtask

   task automatic push_feed(input int f, input int nb, input logic [63:0] base);
      for (int b = 0; b < nb; b++) feed_q[f].push_back('{base + 64'(b), (b == nb - 1)});
   endtask

   task automatic push_exp(input int f, input int nb, input logic [63:0] base);
      for (int b = 0; b < nb; b++) exp_q.push_back('{base + 64'(b), (b == nb - 1), f});
   endtask

   // One clock: monitor at the falling edge, then advance the feed drivers after the rising edge.
   task automatic cycle();
      logic [N-1:0] fire;
      logic [N-1:0] allowed;
      exp_t         e;
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
         mbeats++;
         if (exp_q.size() == 0)
            check("sb_unexpected_beat", m_axis_tdata, 64'hDEAD);
         else begin
            e = exp_q.pop_front();
            check("sb_data", m_axis_tdata, e.data);
            check("sb_last", 64'(m_axis_tlast), 64'(e.last));
            check("sb_feed", 64'(grant_id), 64'(e.feed));
         end
      end
      if (pkt_done)    pd_cnt++;
      if (err_timeout) to_cnt++;
      if (grant_valid && !gv_prev) grant_log.push_back(int'(grant_id));
      gv_prev = grant_valid;
      allowed = grant_valid ? (N'(1) << grant_id) : '0;
      check("tready_only_owner", 64'(s_axis_tready & ~allowed), 64'd0);
      if (chk_mirror && grant_valid)
         check("tready_mirror", 64'(s_axis_tready[grant_id]), 64'(m_axis_tready));
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (fire[i] && feed_q[i].size() > 0) void'(feed_q[i].pop_front());
      drive_feeds();
      if (bp_toggle) m_axis_tready = ~m_axis_tready;
   endtask

   function automatic logic all_idle();
      logic busy;
      busy = grant_valid || (exp_q.size() != 0);
      for (int i = 0; i < N; i++) if (feed_q[i].size() != 0) busy = 1'b1;
      return !busy;
   endfunction

   task automatic run_until_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!all_idle() && n < budget);
      check({"idle_reached_", name}, 64'(all_idle()), 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      clear_all();
      m_axis_tready = 1'b1;
      gv_prev = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec[11];
      int   p0, b0, to0, idle_cnt, n;
      logic started;
      int   exp_ord[5];

      // Round-robin pointer after each record is exp_grant+1; records run back to back from reset.
      vec[0]  = '{4'b1111, 0};
      vec[1]  = '{4'b1111, 1};
      vec[2]  = '{4'b0001, 0};
      vec[3]  = '{4'b1000, 3};
      vec[4]  = '{4'b0110, 1};
      vec[5]  = '{4'b0011, 0};
      vec[6]  = '{4'b1001, 3};
      vec[7]  = '{4'b1100, 2};
      vec[8]  = '{4'b1111, 3};
      vec[9]  = '{4'b0100, 2};
      vec[10] = '{4'b0101, 0};

      n_checks = 0; n_err = 0; mbeats = 0; pd_cnt = 0; to_cnt = 0;
      hold = '0; bp_toggle = 1'b0; chk_mirror = 1'b0; gv_prev = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
      m_axis_tready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_grant_valid", 64'(grant_valid), 64'd0);
      check("rst_grant_id", 64'(grant_id), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_pkt_done", 64'(pkt_done), 64'd0);
      check("rst_err_timeout", 64'(err_timeout), 64'd0);
      do_reset();

      // Arbitration table: single-beat packets, losers withdrawn after each grant.
      for (int r = 0; r < 11; r++) begin
         for (int i = 0; i < N; i++)
            if (vec[r].mask[i]) feed_q[i].push_back('{64'h5A00 + 64'(r * 16 + i), 1'b1});
         exp_q.push_back('{64'h5A00 + 64'(r * 16 + vec[r].exp_grant), 1'b1, vec[r].exp_grant});
         drive_feeds();
         cycle();
         check("arb_grant_valid", 64'(grant_valid), 64'd1);
         check("arb_grant_id", 64'(grant_id), 64'(vec[r].exp_grant));
         cycle();
         clear_all();
         check("arb_release", 64'(grant_valid), 64'd0);
      end

      // Single feed, 5 beats; grant one cycle after tvalid.
      p0 = pd_cnt; b0 = mbeats;
      push_feed(0, 5, 64'hAABBCCDD11223344);
      push_exp(0, 5, 64'hAABBCCDD11223344);
      drive_feeds();
      check("t1_no_grant_yet", 64'(grant_valid), 64'd0);
      cycle();
      check("t1_grant_valid", 64'(grant_valid), 64'd1);
      check("t1_grant_id", 64'(grant_id), 64'd0);
      run_until_idle("t1", 30);
      check("t1_beats", 64'(mbeats - b0), 64'd5);
      check("t1_pkt_done", 64'(pd_cnt - p0), 64'd1);

      // All feeds valid with 2-beat packets, feed0 has a second packet queued.
      do_reset();
      grant_log.delete();
      p0 = pd_cnt; b0 = mbeats;
      for (int f = 0; f < N; f++) push_feed(f, 2, 64'h2000 + 64'(f * 16));
      push_feed(0, 2, 64'h2100);
      for (int f = 0; f < N; f++) push_exp(f, 2, 64'h2000 + 64'(f * 16));
      push_exp(0, 2, 64'h2100);
      drive_feeds();
      idle_cnt = 0; started = 1'b0; n = 0;
      do begin
         cycle();
         n++;
         if (grant_valid) started = 1'b1;
         else if (started && exp_q.size() != 0) idle_cnt++;
      end while (!all_idle() && n < 60);
      check("t2_idle_reached", 64'(all_idle()), 64'd1);
      check("t2_bubbles", 64'(idle_cnt), 64'd4);
      check("t2_beats", 64'(mbeats - b0), 64'd10);
      check("t2_pkt_done", 64'(pd_cnt - p0), 64'd5);
      exp_ord = '{0, 1, 2, 3, 0};
      check("t2_grant_count", 64'(grant_log.size()), 64'd5);
      if (grant_log.size() == 5)
         for (int k = 0; k < 5; k++) check("t2_grant_order", 64'(grant_log[k]), 64'(exp_ord[k]));

      // Decoder back-pressure while feed1 streams; rr_ptr is 1 so feed1 wins, then 2, then 0.
      b0 = mbeats;
      push_feed(1, 5, 64'h3100); push_feed(0, 2, 64'h3000); push_feed(2, 2, 64'h3200);
      push_exp(1, 5, 64'h3100);  push_exp(2, 2, 64'h3200);  push_exp(0, 2, 64'h3000);
      drive_feeds();
      bp_toggle = 1'b1; chk_mirror = 1'b1;
      run_until_idle("t3", 80);
      bp_toggle = 1'b0; chk_mirror = 1'b0; m_axis_tready = 1'b1;
      check("t3_beats", 64'(mbeats - b0), 64'd9);

      // Reset on beat 3 of feed2's packet, with rr_ptr moved to 2 beforehand.
      do_reset();
      push_feed(1, 1, 64'h4100); push_exp(1, 1, 64'h4100);
      drive_feeds();
      run_until_idle("t4_pre", 10);
      b0 = mbeats;
      push_feed(2, 5, 64'h4200); push_exp(2, 5, 64'h4200);
      drive_feeds();
      n = 0;
      while (mbeats - b0 < 2 && n < 20) begin
         cycle();
         n++;
      end
      check("t4_two_beats", 64'(mbeats - b0), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("t4_m_tdata", m_axis_tdata, 64'd0);
      check("t4_s_tready", 64'(s_axis_tready), 64'd0);
      check("t4_grant_valid", 64'(grant_valid), 64'd0);
      check("t4_grant_id", 64'(grant_id), 64'd0);
      check("t4_pkt_done", 64'(pkt_done), 64'd0);
      exp_q.delete();
      clear_all();
      gv_prev = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_feed(1, 1, 64'h4A10); push_feed(3, 1, 64'h4A30);
      push_exp(1, 1, 64'h4A10);  push_exp(3, 1, 64'h4A30);
      drive_feeds();
      run_until_idle("t4_post", 20);

      // Back-to-back single-beat packets on feeds 0 and 1 (rr_ptr is 0 here).
      grant_log.delete();
      p0 = pd_cnt;
      push_feed(0, 1, 64'h6000); push_feed(1, 1, 64'h6100);
      push_exp(0, 1, 64'h6000);  push_exp(1, 1, 64'h6100);
      drive_feeds();
      run_until_idle("t6", 10);
      check("t6_pkt_done", 64'(pd_cnt - p0), 64'd2);
      check("t6_grant_count", 64'(grant_log.size()), 64'd2);
      if (grant_log.size() == 2) begin
         check("t6_first", 64'(grant_log[0]), 64'd0);
         check("t6_second", 64'(grant_log[1]), 64'd1);
      end

`ifdef ITCH_ARB_TIMEOUT_EN
      // Feed2 stalls mid-packet: terminator beat, remainder drained, feed3 next.
      p0 = pd_cnt; to0 = to_cnt;
      push_feed(2, 4, 64'h5200); push_feed(3, 1, 64'h5300);
      push_exp(2, 2, 64'h5200);
      exp_q.push_back('{64'd0, 1'b1, 2});
      push_exp(3, 1, 64'h5300);
      drive_feeds();
      n = 0;
      while (feed_q[2].size() > 2 && n < 20) begin
         cycle();
         n++;
      end
      hold[2] = 1'b1;
      drive_feeds();
      n = 0;
      while (to_cnt == to0 && n < 40) begin
         cycle();
         n++;
      end
      check("t5_timeout_latency", 64'(n), 64'd16);
      repeat (3) cycle();
      hold[2] = 1'b0;
      drive_feeds();
      run_until_idle("t5", 40);
      check("t5_err_count", 64'(to_cnt - to0), 64'd1);
      check("t5_pkt_done", 64'(pd_cnt - p0), 64'd1);
`else
      // Without the watchdog a stalled feed keeps the grant indefinitely.
      to0 = to_cnt;
      push_feed(3, 4, 64'h5300); push_exp(3, 4, 64'h5300);
      drive_feeds();
      n = 0;
      while (feed_q[3].size() > 2 && n < 20) begin
         cycle();
         n++;
      end
      hold[3] = 1'b1;
      drive_feeds();
      repeat (40) cycle();
      check("stall_grant_valid", 64'(grant_valid), 64'd1);
      check("stall_grant_id", 64'(grant_id), 64'd3);
      check("stall_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("stall_no_timeout", 64'(to_cnt - to0), 64'd0);
      hold[3] = 1'b0;
      drive_feeds();
      run_until_idle("stall", 20);
`endif

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
